// File: rtl/mac_scheduler_pkg.sv
// Shared types and constants for the MAC burst scheduler.
package mac_sched_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int N_REQ = 3;
  localparam int LEN_W = 8;

  function automatic int ptr_wrap(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/mac_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first pending index at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0]         pending,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 valid,
  output logic [$clog2(N)-1:0] winner
);
  localparam int SW = $clog2(N);

  int w_idx;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    w_idx  = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = int'(ptr) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!valid && pending[w_idx[SW-1:0]]) begin
        valid  = 1'b1;
        winner = w_idx[SW-1:0];
      end
    end
  end
endmodule

// File: rtl/mac_scheduler.sv
// Time-shares one MAC datapath among N burst requesters, round-robin, with
// registered sequencing strobes, per-burst done pulses and sticky overrun flags.
module mac_scheduler
  import mac_sched_pkg::*;
#(
  parameter int N  = N_REQ,
  parameter int LW = LEN_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en_frame,
  input  logic [N-1:0]         req,
  input  logic [N*LW-1:0]      len,
  output logic [N-1:0]         done,
  output logic                 mac_en,
  output logic [$clog2(N)-1:0] mac_sel,
  output logic                 mac_first,
  output logic                 mac_last,
  output logic                 busy,
  input  logic                 ovr_clr,
  output logic [N-1:0]         overrun
);
  localparam int SW = $clog2(N);

  state_t          r_state;
  logic [SW-1:0]   r_sel;
  logic [SW-1:0]   r_ptr;
  logic [LW-1:0]   r_cnt;
  logic [N-1:0]    r_pending;
  logic [LW-1:0]   r_len [N];
  logic [N-1:0]    r_done;
  logic            r_mac_en;
  logic [SW-1:0]   r_mac_sel;
  logic            r_mac_first;
  logic            r_mac_last;
  logic [N-1:0]    r_overrun;

  logic            w_valid;
  logic [SW-1:0]   w_winner;
  logic [LW-1:0]   w_win_len;
  logic [N-1:0]    w_in_service;
  logic [N-1:0]    w_accept;
  logic [N-1:0]    w_clr;
  logic [N-1:0]    w_ovr_set;

  rr_arbiter #(.N(N)) u_arb (
    .pending (r_pending),
    .ptr     (r_ptr),
    .valid   (w_valid),
    .winner  (w_winner)
  );

  // The requester in service stays "busy" through its DONE cycle, so a
  // re-request coinciding with its done pulse counts as an overrun.
  always_comb begin
    w_in_service = '0;
    if (r_state != IDLE) w_in_service[r_sel] = 1'b1;
    w_clr = '0;
    if (r_state == IDLE && w_valid) w_clr[w_winner] = 1'b1;
    w_accept  = req & ~r_pending & ~w_in_service;
    w_ovr_set = (req & ~w_accept) | ({N{en_frame}} & (r_pending | w_in_service));
    w_win_len = r_len[w_winner];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
      r_overrun <= '0;
      for (int i = 0; i < N; i++) r_len[i] <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_accept;
      r_overrun <= (ovr_clr ? '0 : r_overrun) | w_ovr_set;
      for (int i = 0; i < N; i++)
        if (w_accept[i]) r_len[i] <= len[i*LW +: LW];
    end
  end

  // r_cnt holds the RUN cycles remaining after the current one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_sel       <= '0;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_done      <= '0;
      r_mac_en    <= 1'b0;
      r_mac_sel   <= '0;
      r_mac_first <= 1'b0;
      r_mac_last  <= 1'b0;
    end else begin
      r_done <= '0;
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_sel <= w_winner;
            r_cnt <= w_win_len - 1'b1;
            if (w_win_len == '0) begin
              r_state          <= DONE;
              r_done[w_winner] <= 1'b1;
            end else begin
              r_state     <= RUN;
              r_mac_en    <= 1'b1;
              r_mac_sel   <= w_winner;
              r_mac_first <= 1'b1;
              r_mac_last  <= (w_win_len == LW'(1));
            end
          end
        end
        RUN: begin
          r_mac_first <= 1'b0;
          if (r_cnt == '0) begin
            r_state       <= DONE;
            r_mac_en      <= 1'b0;
            r_mac_last    <= 1'b0;
            r_done[r_sel] <= 1'b1;
          end else begin
            r_cnt      <= r_cnt - 1'b1;
            r_mac_last <= (r_cnt == LW'(1));
          end
        end
        DONE: begin
          r_ptr   <= SW'(ptr_wrap(int'(r_sel), N));
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign done      = r_done;
  assign mac_en    = r_mac_en;
  assign mac_sel   = r_mac_sel;
  assign mac_first = r_mac_first;
  assign mac_last  = r_mac_last;
  assign busy      = (r_state != IDLE);
  assign overrun   = r_overrun;
endmodule

// File: tb/tb_mac_scheduler.sv
// Scenario bench for mac_scheduler; done pulses are scored against a queue of expected (index, cycle) pairs.
module tb_mac_scheduler;
  localparam int N  = 3;
  localparam int LW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            en_frame;
  logic [N-1:0]    req;
  logic [N*LW-1:0] len;
  logic [N-1:0]    done;
  logic            mac_en;
  logic [1:0]      mac_sel;
  logic            mac_first;
  logic            mac_last;
  logic            busy;
  logic            ovr_clr;
  logic [N-1:0]    overrun;

  typedef struct {int idx; int cyc;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  int checks = 0;
  int failures = 0;

  mac_scheduler #(.N(N), .LW(LW)) dut (
    .clk(clk), .reset(reset), .en_frame(en_frame), .req(req), .len(len),
    .done(done), .mac_en(mac_en), .mac_sel(mac_sel), .mac_first(mac_first),
    .mac_last(mac_last), .busy(busy), .ovr_clr(ovr_clr), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    req = '0; en_frame = 1'b0; ovr_clr = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    clear_inputs(); len = '0; reset = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if (done !== 3'b000) begin failures++; $display("FAIL rst_done got=%b want=000", done); end
    checks++; if (mac_en !== 1'b0) begin failures++; $display("FAIL rst_mac_en got=%b want=0", mac_en); end
    checks++; if (mac_sel !== 2'd0) begin failures++; $display("FAIL rst_mac_sel got=%0d want=0", mac_sel); end
    checks++; if (mac_first !== 1'b0 || mac_last !== 1'b0) begin failures++; $display("FAIL rst_first_last got=%b%b want=00", mac_first, mac_last); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", busy); end
    checks++; if (overrun !== 3'b000) begin failures++; $display("FAIL rst_overrun got=%b want=000", overrun); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (done[i]) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL single_done unexpected idx=%0d c=%0d", i, c); end
        else begin e = exp_q.pop_front();
          if (e.idx != i || e.cyc != c) begin failures++; $display("FAIL single_done got=%0d@%0d want=%0d@%0d", i, c, e.idx, e.cyc); end
        end
      end
      checks++; if (mac_en !== (c >= 2 && c <= 5)) begin failures++; $display("FAIL single_en c=%0d got=%b", c, mac_en); end
      checks++; if (mac_first !== (c == 2)) begin failures++; $display("FAIL single_first c=%0d got=%b", c, mac_first); end
      checks++; if (mac_last !== (c == 5)) begin failures++; $display("FAIL single_last c=%0d got=%b", c, mac_last); end
      checks++; if (busy !== (c >= 2 && c <= 6)) begin failures++; $display("FAIL single_busy c=%0d got=%b", c, busy); end
      if (mac_en) begin checks++; if (mac_sel !== 2'd0) begin failures++; $display("FAIL single_sel got=%0d want=0", mac_sel); end end
      clear_inputs();
      if (c == 0) begin req[0] = 1'b1; len[0 +: LW] = 8'd4; exp_q.push_back('{0, 6}); end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL single_missing got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 18; c++) begin
        @(negedge clk);
        for (int i = 0; i < N; i++) if (done[i]) begin
          checks++;
          if (exp_q.size() == 0) begin failures++; $display("FAIL rr_done unexpected idx=%0d c=%0d", i, c); end
          else begin e = exp_q.pop_front();
            if (e.idx != i || e.cyc != c) begin failures++; $display("FAIL rr_done got=%0d@%0d want=%0d@%0d", i, c, e.idx, e.cyc); end
          end
        end
        checks++; if (mac_first !== (c == 2 || c == 7 || c == 12)) begin failures++; $display("FAIL rr_first r=%0d c=%0d got=%b", r, c, mac_first); end
        if (mac_first) begin
          checks++; if (mac_sel !== 2'((c - 2) / 5)) begin failures++; $display("FAIL rr_order r=%0d c=%0d got=%0d want=%0d", r, c, mac_sel, (c - 2) / 5); end
        end
        clear_inputs();
        if (c == 0) begin
          req = 3'b111; len = {8'd3, 8'd3, 8'd3};
          exp_q.push_back('{0, 5}); exp_q.push_back('{1, 10}); exp_q.push_back('{2, 15});
        end
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rr_missing r=%0d got=%0d want=0", r, exp_q.size()); end
    end
  endtask

  task automatic test_edge_len();
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (done[i]) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL len1_done unexpected idx=%0d c=%0d", i, c); end
        else begin e = exp_q.pop_front();
          if (e.idx != i || e.cyc != c) begin failures++; $display("FAIL len1_done got=%0d@%0d want=%0d@%0d", i, c, e.idx, e.cyc); end
        end
      end
      checks++; if (mac_en !== (c == 2)) begin failures++; $display("FAIL len1_en c=%0d got=%b", c, mac_en); end
      if (c == 2) begin
        checks++; if ({mac_first, mac_last, mac_sel} !== 4'b1101) begin failures++; $display("FAIL len1_strobes got=%b want=1101", {mac_first, mac_last, mac_sel}); end
      end
      clear_inputs();
      if (c == 0) begin req[1] = 1'b1; len[LW +: LW] = 8'd1; exp_q.push_back('{1, 3}); end
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (done[i]) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL len0_done unexpected idx=%0d c=%0d", i, c); end
        else begin e = exp_q.pop_front();
          if (e.idx != i || e.cyc != c) begin failures++; $display("FAIL len0_done got=%0d@%0d want=%0d@%0d", i, c, e.idx, e.cyc); end
        end
      end
      checks++; if (mac_en !== 1'b0) begin failures++; $display("FAIL len0_en c=%0d got=%b want=0", c, mac_en); end
      checks++; if (busy !== (c == 2)) begin failures++; $display("FAIL len0_busy c=%0d got=%b", c, busy); end
      clear_inputs();
      if (c == 0) begin req[2] = 1'b1; len[2*LW +: LW] = 8'd0; exp_q.push_back('{2, 2}); end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL edge_missing got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_overrun();
    apply_reset();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (done[i]) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL ovr_done unexpected idx=%0d c=%0d", i, c); end
        else begin e = exp_q.pop_front();
          if (e.idx != i || e.cyc != c) begin failures++; $display("FAIL ovr_done got=%0d@%0d want=%0d@%0d", i, c, e.idx, e.cyc); end
        end
      end
      if (c == 8)  begin checks++; if (overrun !== 3'b010) begin failures++; $display("FAIL ovr_repeat got=%b want=010", overrun); end end
      if (c == 15) begin checks++; if (overrun !== 3'b110) begin failures++; $display("FAIL ovr_frame got=%b want=110", overrun); end end
      if (c == 21) begin checks++; if (overrun !== 3'b000) begin failures++; $display("FAIL ovr_clear got=%b want=000", overrun); end end
      if (c == 26) begin checks++; if (overrun !== 3'b001) begin failures++; $display("FAIL ovr_set_wins got=%b want=001", overrun); end end
      if (c == 28) begin checks++; if (overrun !== 3'b000) begin failures++; $display("FAIL ovr_clear2 got=%b want=000", overrun); end end
      if (c == 29) begin checks++; if (overrun !== 3'b001) begin failures++; $display("FAIL ovr_req_at_done got=%b want=001", overrun); end end
      if (c == 31) begin checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ovr_dropped_busy got=%b want=0", busy); end end
      clear_inputs();
      case (c)
        0:  begin req[1] = 1'b1; len[LW +: LW] = 8'd5; exp_q.push_back('{1, 7}); end
        1:  begin req[1] = 1'b1; len[LW +: LW] = 8'd5; end
        10: begin req[2] = 1'b1; len[2*LW +: LW] = 8'd6; exp_q.push_back('{2, 18}); end
        14: en_frame = 1'b1;
        20: ovr_clr = 1'b1;
        22: begin req[0] = 1'b1; len[0 +: LW] = 8'd4; exp_q.push_back('{0, 28}); end
        25: begin en_frame = 1'b1; ovr_clr = 1'b1; end
        27: ovr_clr = 1'b1;
        28: begin req[0] = 1'b1; len[0 +: LW] = 8'd4; end
        default: ;
      endcase
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL ovr_missing got=%0d want=0", exp_q.size()); end
    apply_reset();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (done[i]) begin
        checks++; failures++; $display("FAIL rmid_done unexpected idx=%0d c=%0d want none", i, c);
      end
      clear_inputs();
      reset = (c == 4);
      if (c == 0) begin req[0] = 1'b1; len[0 +: LW] = 8'd10; end
      if (c == 4) begin
        #1;
        checks++; if (mac_en !== 1'b0) begin failures++; $display("FAIL rmid_en got=%b want=0", mac_en); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b want=0", busy); end
      end
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (done[i]) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL rmid2_done unexpected idx=%0d c=%0d", i, c); end
        else begin e = exp_q.pop_front();
          if (e.idx != i || e.cyc != c) begin failures++; $display("FAIL rmid2_done got=%0d@%0d want=%0d@%0d", i, c, e.idx, e.cyc); end
        end
      end
      checks++; if ({mac_en, mac_first, mac_last} !== {c >= 2 && c <= 5, c == 2, c == 5}) begin
        failures++; $display("FAIL rmid2_strobes c=%0d got=%b", c, {mac_en, mac_first, mac_last});
      end
      clear_inputs();
      if (c == 0) begin req[0] = 1'b1; len[0 +: LW] = 8'd4; exp_q.push_back('{0, 6}); end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rmid2_missing got=%0d want=0", exp_q.size()); end
  endtask

  // Requests land 6 cycles after the frame strobe, so the third 80-cycle
  // burst is still running when the next strobe arrives 250 cycles later.
  task automatic test_throughput();
    apply_reset();
    for (int c = 0; c < 258; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (done[i]) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL thr_done unexpected idx=%0d c=%0d", i, c); end
        else begin e = exp_q.pop_front();
          if (e.idx != i || e.cyc != c) begin failures++; $display("FAIL thr_done got=%0d@%0d want=%0d@%0d", i, c, e.idx, e.cyc); end
        end
      end
      if (c == 1)   begin checks++; if (overrun !== 3'b000) begin failures++; $display("FAIL thr_idle_frame got=%b want=000", overrun); end end
      if (c == 251) begin checks++; if (overrun !== 3'b100) begin failures++; $display("FAIL thr_overrun got=%b want=100", overrun); end end
      clear_inputs();
      if (c == 0 || c == 250) en_frame = 1'b1;
      if (c == 6) begin
        req = 3'b111; len = {8'd80, 8'd80, 8'd80};
        exp_q.push_back('{0, 88}); exp_q.push_back('{1, 170}); exp_q.push_back('{2, 252});
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL thr_missing got=%0d want=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_edge_len();
    test_overrun();
    test_reset_mid();
    test_throughput();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
